xpb_acc_lut: RTL and testbench
==============================

# xpb_acc_lut

Loadable, multi-segment XPB lookup-and-accumulate engine for the modular-squaring datapath. It takes one request of NUM_SEG packed reduction indices and reads one precomputed XPB word per index from a per-segment table. It adds the looked-up words and returns their sum over a valid/ready handshake. The tables are written at runtime over a load port, so one netlist serves any modulus.

## Interface
Parameters:
- WORD_W, 1024, width of one XPB table word
- IDX_W, 5, index bits per segment (table depth 2^IDX_W)
- NUM_SEG, 4, number of segments/tables per request
- SUM_W, WORD_W+$clog2(NUM_SEG), width of the accumulated result (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  reset, asynchronous and active-high
- tbl_we  in  1  table write strobe
- tbl_seg  in  $clog2(NUM_SEG)  target segment table
- tbl_idx  in  IDX_W  target entry
- tbl_data  in  WORD_W  entry value
- in_valid  in  1  request valid
- in_ready  out  1  engine can accept a request
- in_idx  in  NUM_SEG*IDX_W  packed indices; segment k at bits [k*IDX_W +: IDX_W]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  SUM_W  sum of the NUM_SEG looked-up words
- busy  out  1  FSM not in IDLE

## Operation
- Tables: NUM_SEG x 2^IDX_W x WORD_W synchronous RAM. Write on tbl_we at the clock edge. Read has 1-cycle registered latency. Contents are not cleared by rst.
- FSM states: IDLE, LOOK, DRAIN, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_idx, clear the accumulator and seg counter, then go to LOOK.
  - LOOK: each cycle issues a read of table[seg][idx_seg] and increments seg. After the read for seg NUM_SEG-1 is issued, go to DRAIN.
  - Accumulation: each returned read word is zero-extended to SUM_W and added into the accumulator the cycle after its read.
  - DRAIN: absorbs the last read word. Then latch the accumulator into out_sum and go to DONE.
  - DONE: out_valid=1 and out_sum is held stable. On out_ready, go to IDLE.
- in_ready is 1 only in IDLE. There is no overlap of requests.
- The sum never wraps, because SUM_W carries the carry bits.
- Table write during LOOK to the entry being read in the same cycle: the read returns the old data (read-before-write). Writes to other entries are unaffected.
- Table writes are legal in every state and during reset.
- tbl_seg >= NUM_SEG (non-power-of-two NUM_SEG): the write is ignored.
- Reset mid-operation: the FSM returns to IDLE, the accumulator clears, and the pending request is lost.

## Timing
- Reset values: in_ready=1 after reset deasserts (0 while rst high), out_valid=0, out_sum=0, busy=0.
- Accept at edge T → reads issued at T+1..T+NUM_SEG → out_valid high from T+NUM_SEG+2. Latency is NUM_SEG+2 cycles (6 at default).
- Throughput is one request per NUM_SEG+3 cycles when out_ready is held high (the DONE→IDLE cycle is included).
- out_valid falls the cycle after the out_ready handshake. in_ready rises in that same cycle.

## Configuration
- XPB_ACC_ZERO_IDX_EN defined: an index of 0 contributes 0 regardless of table contents. The read for that segment is still sequenced, so latency is unchanged.
- Undefined: index 0 returns whatever table entry 0 holds (the loader must write 0).

## Structure
- Package xpb_acc_pkg holds:
  - the FSM state enum;
  - the default WORD_W/IDX_W/NUM_SEG localparams;
  - a function computing SUM_W.
- One sub-module: xpb_seg_ram (single table: write port plus registered read port), instantiated NUM_SEG times via generate. The FSM and accumulator stay in the top.

## Test plan
- Reset, then idle: out_valid=0, out_sum=0, in_ready=1, busy=0.
- Default params: load seg k, idx i = i+16*k for all entries; request indices {3,2,1,0} (seg3..seg0) → out_sum = 0+17+34+51 = 0x66 at exactly 6 cycles after accept.
- Overflow: all four tables idx 31 = all-ones WORD_W; request all-31 → out_sum = 4*(2^1024-1), with the top two bits of SUM_W set.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_sum stable and in_ready=0 with in_valid high; release → in_ready=1 the next cycle.
- Write collision: during LOOK, write seg1 idx5 = 0xAA in the same cycle that seg1 idx5 (old value 0x11) is read → sum uses 0x11; the next request uses 0xAA.
- Mid-operation reset, plus the macro: assert rst in LOOK → IDLE and out_valid=0. With XPB_ACC_ZERO_IDX_EN and table entry 0 = 0xFF, an all-zero request → out_sum=0 (0x3FC without the macro).

Source files
------------

// File: rtl/xpb_acc_pkg.sv
// Shared types and defaults for the XPB lookup-and-accumulate engine.
package xpb_acc_pkg;

  // Engine control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOOK  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } xpb_state_e;

  localparam int DEF_WORD_W  = 1024;
  localparam int DEF_IDX_W   = 5;
  localparam int DEF_NUM_SEG = 4;

  // Result width: one word plus enough carry bits for NUM_SEG additions
  function automatic int xpb_sum_w(input int word_w, input int num_seg);
    return word_w + $clog2(num_seg);
  endfunction

endpackage

// File: rtl/xpb_seg_ram.sv
// One XPB segment table: synchronous write port plus a registered read port.
// A read and a write to the same entry in one cycle return the old contents.
// Contents have no reset, so the table can be loaded while the engine is in reset.
module xpb_seg_ram #(
  parameter int WORD_W = 1024,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_r [2**IDX_W];
  logic [WORD_W-1:0] rdata_r;

  // Table write and registered read; both nonblocking so reads see pre-write data
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/xpb_acc_lut.sv
// XPB lookup-and-accumulate engine: one request carries NUM_SEG indices, each
// selects a word from its own runtime-loaded table, and the words are summed.
// Optional macro XPB_ACC_ZERO_IDX_EN: an index of 0 contributes zero regardless
// of the table contents (the read is still sequenced, latency is unchanged).
module xpb_acc_lut
  import xpb_acc_pkg::*;
#(
  parameter  int WORD_W  = DEF_WORD_W,
  parameter  int IDX_W   = DEF_IDX_W,
  parameter  int NUM_SEG = DEF_NUM_SEG,
  localparam int SUM_W   = xpb_sum_w(WORD_W, NUM_SEG)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tbl_we,
  input  logic [$clog2(NUM_SEG)-1:0] tbl_seg,
  input  logic [IDX_W-1:0]           tbl_idx,
  input  logic [WORD_W-1:0]          tbl_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_SEG*IDX_W-1:0]   in_idx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SUM_W-1:0]           out_sum,
  output logic                       busy
);

  localparam int SEG_W = $clog2(NUM_SEG);
  localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NUM_SEG - 1);

  xpb_state_e               state_r;
  xpb_state_e               state_nxt_s;
  logic [SEG_W-1:0]         seg_r;
  logic [NUM_SEG*IDX_W-1:0] idx_r;
  logic                     rd_vld_r;
  logic [SEG_W-1:0]         rd_seg_r;
  logic [SUM_W-1:0]         acc_r;
  logic [SUM_W-1:0]         out_sum_r;
  logic                     out_valid_r;
  logic                     in_ready_r;
  logic                     busy_r;
  logic                     accept_s;
  logic [IDX_W-1:0]         look_idx_s;
  logic [WORD_W-1:0]        add_word_s;
  logic [WORD_W-1:0]        rd_word_s [NUM_SEG];
`ifdef XPB_ACC_ZERO_IDX_EN
  logic                     rd_zero_r;
`endif

  assign accept_s = in_valid && in_ready_r && (state_r == ST_IDLE);

  // Index of the segment being read this cycle
  always_comb begin
    look_idx_s = idx_r[seg_r*IDX_W +: IDX_W];
  end

  // One table per segment; a write to a segment number with no table matches nothing
  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    logic we_s;
    logic re_s;
    assign we_s = tbl_we && (tbl_seg == SEG_W'(k));
    assign re_s = (state_r == ST_LOOK) && (seg_r == SEG_W'(k));
    xpb_seg_ram #(
      .WORD_W (WORD_W),
      .IDX_W  (IDX_W)
    ) u_ram (
      .clk   (clk),
      .we    (we_s),
      .waddr (tbl_idx),
      .wdata (tbl_data),
      .re    (re_s),
      .raddr (look_idx_s),
      .rdata (rd_word_s[k])
    );
  end

  // Word returned by the read issued last cycle, masked for index 0 when enabled
  always_comb begin
`ifdef XPB_ACC_ZERO_IDX_EN
    if (rd_zero_r) begin
      add_word_s = '0;
    end else begin
      add_word_s = rd_word_s[rd_seg_r];
    end
`else
    add_word_s = rd_word_s[rd_seg_r];
`endif
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: DRAIN waits until the last read word has been absorbed
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_LOOK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOOK: begin
        if (seg_r == LAST_SEG) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_LOOK;
        end
      end
      ST_DRAIN: begin
        if (!rd_vld_r) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Handshake/status outputs registered from the next state so they align with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  // Request latch, read sequencing, accumulation and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r     <= '0;
      seg_r     <= '0;
      rd_vld_r  <= 1'b0;
      rd_seg_r  <= '0;
      acc_r     <= '0;
      out_sum_r <= '0;
`ifdef XPB_ACC_ZERO_IDX_EN
      rd_zero_r <= 1'b0;
`endif
    end else begin
      rd_vld_r <= (state_r == ST_LOOK);
      rd_seg_r <= seg_r;
`ifdef XPB_ACC_ZERO_IDX_EN
      rd_zero_r <= (look_idx_s == {IDX_W{1'b0}});
`endif
      if (accept_s) begin
        idx_r <= in_idx;
        seg_r <= '0;
        acc_r <= '0;
      end else begin
        if (state_r == ST_LOOK) begin
          seg_r <= seg_r + SEG_W'(1);
        end
        if (rd_vld_r) begin
          acc_r <= acc_r + SUM_W'(add_word_s);
        end
      end
      if ((state_r == ST_DRAIN) && !rd_vld_r) begin
        out_sum_r <= acc_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_xpb_acc_lut.sv
// Bench for xpb_acc_lut: directed steps plus random table/index traffic, all
// results compared against a table-and-sum reference model held in the bench.
module tb_xpb_acc_lut;

  localparam int WORD_W  = 1024;
  localparam int IDX_W   = 5;
  localparam int NUM_SEG = 4;
  localparam int SUM_W   = WORD_W + 2;
  localparam int DEPTH   = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     tbl_we;
  logic [1:0]               tbl_seg;
  logic [IDX_W-1:0]         tbl_idx;
  logic [WORD_W-1:0]        tbl_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_SEG*IDX_W-1:0] in_idx;
  logic                     out_valid;
  logic                     out_ready;
  logic [SUM_W-1:0]         out_sum;
  logic                     busy;

  logic [WORD_W-1:0] ref_tbl [NUM_SEG][DEPTH];

  int total  = 0;
  int passed = 0;
  int failed = 0;

  xpb_acc_lut dut (
    .clk       (clk),
    .rst       (rst),
    .tbl_we    (tbl_we),
    .tbl_seg   (tbl_seg),
    .tbl_idx   (tbl_idx),
    .tbl_data  (tbl_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [SUM_W-1:0] obs, input logic [SUM_W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed hi=%h lo=%h expected hi=%h lo=%h",
             tag, obs[SUM_W-1:SUM_W-64], obs[63:0], exp[SUM_W-1:SUM_W-64], exp[63:0]);
    end
  endtask

  // Reference: sum of the addressed table words, index 0 masked when the option is on
  function automatic logic [SUM_W-1:0] model_sum(input logic [NUM_SEG*IDX_W-1:0] idx);
    logic [SUM_W-1:0] s;
    int i;
    s = '0;
    for (int k = 0; k < NUM_SEG; k++) begin
      i = int'(idx[k*IDX_W +: IDX_W]);
`ifdef XPB_ACC_ZERO_IDX_EN
      if (i == 0) continue;
`endif
      s = s + {2'b00, ref_tbl[k][i]};
    end
    return s;
  endfunction

  function automatic logic [WORD_W-1:0] rand_word();
    logic [WORD_W-1:0] w;
    for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic tbl_write(input int seg, input int idx, input logic [WORD_W-1:0] d);
    tbl_we   = 1'b1;
    tbl_seg  = 2'(seg);
    tbl_idx  = 5'(idx);
    tbl_data = d;
    @(posedge clk); #1;
    tbl_we = 1'b0;
    ref_tbl[seg][idx] = d;
  endtask

  // One request. coll: write (cseg,cidx)=cdata in the cycle seg cseg is read.
  // hold: cycles to stall in DONE with a new request pending.
  task automatic run_req(input string tag, input logic [NUM_SEG*IDX_W-1:0] idx,
                         input bit coll, input int cseg, input int cidx,
                         input logic [WORD_W-1:0] cdata, input int hold);
    int cnt;
    bit stable;
    logic [SUM_W-1:0] exp;
    exp = model_sum(idx);
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    check({tag, "_ready"}, SUM_W'(in_ready), SUM_W'(1));
    in_valid = 1'b1;
    in_idx   = idx;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, SUM_W'(busy), SUM_W'(1));
    cnt = 0;
    if (coll) begin
      repeat (cseg) begin
        @(posedge clk); #1; cnt++;
      end
      tbl_we   = 1'b1;
      tbl_seg  = 2'(cseg);
      tbl_idx  = 5'(cidx);
      tbl_data = cdata;
      @(posedge clk); #1; cnt++;
      tbl_we = 1'b0;
      ref_tbl[cseg][cidx] = cdata;
    end
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    check({tag, "_lat"}, SUM_W'(cnt), SUM_W'(6));
    check({tag, "_sum"}, out_sum, exp);
    if (hold > 0) begin
      stable   = 1'b1;
      in_valid = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (out_sum !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
      end
      check({tag, "_hold"}, SUM_W'(stable), SUM_W'(1));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_ovfall"}, SUM_W'(out_valid), SUM_W'(0));
    check({tag, "_irrise"}, SUM_W'(in_ready), SUM_W'(1));
  endtask

  initial begin
    logic [SUM_W-1:0] s1;
    logic [SUM_W-1:0] s2;
    logic [NUM_SEG*IDX_W-1:0] ridx;
    rst       = 1'b1;
    tbl_we    = 1'b0;
    tbl_seg   = 2'd0;
    tbl_idx   = 5'd0;
    tbl_data  = '0;
    in_valid  = 1'b0;
    in_idx    = '0;
    out_ready = 1'b0;

    // Load seg k, entry i = i + 16*k while reset is held
    @(posedge clk); #1;
    for (int k = 0; k < NUM_SEG; k++)
      for (int i = 0; i < DEPTH; i++)
        tbl_write(k, i, WORD_W'(i + 16 * k));
    check("rst_in_ready", SUM_W'(in_ready), SUM_W'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_out_valid", SUM_W'(out_valid), SUM_W'(0));
    check("idle_out_sum", out_sum, SUM_W'(0));
    check("idle_in_ready", SUM_W'(in_ready), SUM_W'(1));
    check("idle_busy", SUM_W'(busy), SUM_W'(0));

    // Indices {3,2,1,0} -> 0+17+34+51
    run_req("pat", 20'h18820, 1'b0, 0, 0, '0, 0);
    check("pat_const", out_sum, SUM_W'(12'h066));

    // Overflow into the carry bits
    for (int k = 0; k < NUM_SEG; k++) tbl_write(k, 31, {WORD_W{1'b1}});
    run_req("ovf", 20'hFFFFF, 1'b0, 0, 0, '0, 0);
    s1 = ~SUM_W'(3);
    check("ovf_const", out_sum, s1);

    // Backpressure in DONE with a new request pending
    run_req("bp", 20'h18820, 1'b0, 0, 0, '0, 10);

    // Random table updates and random requests
    for (int n = 0; n < 6; n++) begin
      repeat (3) tbl_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), rand_word());
      ridx = 20'($urandom);
      run_req("rnd", ridx, 1'b0, 0, 0, '0, 0);
    end

    // Read-before-write collision on seg1 idx5
    tbl_write(1, 5, WORD_W'(8'h11));
    run_req("coll_old", 20'h000A0, 1'b1, 1, 5, WORD_W'(8'hAA), 0);
    s1 = out_sum;
    run_req("coll_new", 20'h000A0, 1'b0, 0, 0, '0, 0);
    s2 = out_sum;
    check("coll_delta", s2 - s1, SUM_W'(8'h99));

    // Reset while in LOOK drops the request
    in_valid = 1'b1;
    in_idx   = 20'hFFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mrst_out_valid", SUM_W'(out_valid), SUM_W'(0));
    check("mrst_busy", SUM_W'(busy), SUM_W'(0));
    check("mrst_in_ready", SUM_W'(in_ready), SUM_W'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("mrst_idle", SUM_W'(in_ready), SUM_W'(1));
    check("mrst_out_sum_kept", SUM_W'(out_valid), SUM_W'(0));

    // Entry 0 = 0xFF in all tables, all-zero request
    for (int k = 0; k < NUM_SEG; k++) tbl_write(k, 0, WORD_W'(8'hFF));
    run_req("zero", 20'h00000, 1'b0, 0, 0, '0, 0);
`ifdef XPB_ACC_ZERO_IDX_EN
    check("zero_const", out_sum, SUM_W'(0));
`else
    check("zero_const", out_sum, SUM_W'(12'h3FC));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
